clawgame_session_ctrl: RTL and testbench

//  Parametrised claw-game session controller: the hardware-only successor to the processor-based

---
 rtl/clawgame_session_ctrl.sv | 131 +++++++++++++
 tb/tb_clawgame_session_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clawgame_session_ctrl.sv
// clawgame_session_ctrl: claw-game session controller.
// Runs IDLE/PLAYING/OVER, counts down game seconds from a cycle prescaler,
// scores rising edges on N_CHAN prize sensors (saturating) and keeps a
// high score across sessions.
// Optional build macro: CLAWGAME_BONUS_TIME_EN (each prize adds BONUS_SECONDS).
module clawgame_session_ctrl #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned GAME_SECONDS  = 60,
  parameter int unsigned TIME_W        = 16,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned N_CHAN        = 2,
  parameter int unsigned BONUS_SECONDS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N_CHAN-1:0]  score_in,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               game_active,
  output logic               game_over,
  output logic               sec_tick
);

`ifdef CLAWGAME_BONUS_TIME_EN
  localparam bit BONUS_ENABLED = 1'b1;
`else
  localparam bit BONUS_ENABLED = 1'b0;
`endif

  localparam int unsigned BONUS_EFF = BONUS_ENABLED ? BONUS_SECONDS : 0;
  localparam int unsigned PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned CNT_W     = $clog2(N_CHAN + 1);
  localparam int unsigned TS_W      = TIME_W + 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAYING,
    S_OVER
  } state_t;

  state_t              state;
  logic                start_prev;
  logic [N_CHAN-1:0]   chan_prev;
  logic [PRE_W-1:0]    presc;

  logic                start_edge;
  logic [N_CHAN-1:0]   events;
  logic [CNT_W-1:0]    n_events;
  logic                tick;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_next;
  logic [TS_W-1:0]     time_sum;
  logic [TIME_W-1:0]   time_next;
  logic                expire;

  // Rising-edge detection on start and prize sensors, plus event count
  always_comb begin
    start_edge = start & ~start_prev;
    events     = score_in & ~chan_prev;
    n_events   = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      n_events = n_events + CNT_W'(events[i]);
    end
  end

  // Next score (saturating) and next time_left including optional bonus
  always_comb begin
    tick       = (state == S_PLAYING) && (presc == PRE_W'(CLK_HZ - 1));
    score_sum  = {1'b0, score} + (SCORE_W + 1)'(n_events);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    // Wide sum so decrement and bonus combine before saturation; time_left
    // is at least 1 while playing, so the decrement cannot underflow.
    time_sum   = TS_W'(time_left) - TS_W'(tick)
               + TS_W'(n_events) * TS_W'(BONUS_EFF);
    time_next  = (|time_sum[TS_W-1:TIME_W]) ? '1 : time_sum[TIME_W-1:0];
    // Reaching zero only happens on a tick with no same-cycle bonus
    expire     = tick && (time_sum == '0);
  end

  // Session state machine with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_prev  <= 1'b0;
      chan_prev   <= '0;
      presc       <= '0;
      time_left   <= TIME_W'(GAME_SECONDS);
      score       <= '0;
      high_score  <= '0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      sec_tick    <= 1'b0;
    end else begin
      start_prev <= start;
      chan_prev  <= score_in;
      sec_tick   <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            state       <= S_PLAYING;
            score       <= '0;
            time_left   <= TIME_W'(GAME_SECONDS);
            presc       <= '0;
            game_active <= 1'b1;
            game_over   <= 1'b0;
          end
        end
        S_PLAYING: begin
          presc     <= tick ? '0 : presc + PRE_W'(1);
          score     <= score_next;
          time_left <= time_next;
          sec_tick  <= tick;
          if (expire) begin
            state       <= S_OVER;
            game_active <= 1'b0;
            game_over   <= 1'b1;
            if (score_next > high_score) high_score <= score_next;
          end
        end
        default: begin
          state       <= S_IDLE;
          game_active <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clawgame_session_ctrl.sv
// Self-checking bench for clawgame_session_ctrl.
// Main instance uses CLK_HZ=4, GAME_SECONDS=3, N_CHAN=2, SCORE_W=4; a second
// instance with a 6-second game exercises score saturation.
module tb_clawgame_session_ctrl;
  localparam int unsigned HZ = 4, GS = 3, TW = 16, SW = 4, NC = 2, BS = 2;
  localparam int unsigned GS_SAT = 6;
  localparam int unsigned SMAX = (1 << SW) - 1;
`ifdef CLAWGAME_BONUS_TIME_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NC-1:0] score_in = '0;
  logic [TW-1:0] time_left;
  logic [SW-1:0] score, high_score;
  logic          game_active, game_over, sec_tick;

  logic          start_s = 1'b0;
  logic [NC-1:0] score_in_s = '0;
  logic [TW-1:0] time_left_s;
  logic [SW-1:0] score_s, high_score_s;
  logic          game_active_s, game_over_s, sec_tick_s;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_high = 0;

  clawgame_session_ctrl #(
    .CLK_HZ(HZ), .GAME_SECONDS(GS), .TIME_W(TW), .SCORE_W(SW),
    .N_CHAN(NC), .BONUS_SECONDS(BS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .score_in(score_in),
    .time_left(time_left), .score(score), .high_score(high_score),
    .game_active(game_active), .game_over(game_over), .sec_tick(sec_tick)
  );

  clawgame_session_ctrl #(
    .CLK_HZ(HZ), .GAME_SECONDS(GS_SAT), .TIME_W(TW), .SCORE_W(SW),
    .N_CHAN(NC), .BONUS_SECONDS(BS)
  ) dut_sat (
    .clock(clock), .reset(reset), .start(start_s), .score_in(score_in_s),
    .time_left(time_left_s), .score(score_s), .high_score(high_score_s),
    .game_active(game_active_s), .game_over(game_over_s), .sec_tick(sec_tick_s)
  );

  always #5 clock = ~clock;

  // Sensor pattern for cycle n of a game
  function automatic logic [NC-1:0] stim(input int mode, input int arg, input int n);
    case (mode)
      1: return (n == 2) ? 2'b01 : ((n >= 5) ? 2'b11 : 2'b00);
      2: return 2'($urandom_range(0, 3));
      3: return ((n % 2 == 0) && (n <= 2 * arg)) ? 2'b01 : 2'b00;
      4: return (n == arg) ? 2'b10 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  // Start a game and follow it to OVER plus three cycles, checking every cycle
  task automatic run_game(input int mode, input int arg, input string name,
                          output int over_n, output int unsigned final_score);
    logic [NC-1:0] prev, nv;
    int unsigned exp_score, exp_time, k;
    int t, post;
    bit playing, exp_tick;
    prev = score_in;
    over_n = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++; if (game_active !== 1'b1) begin errors++; $display("FAIL %s start game_active got %b want 1", name, game_active); end
    checks++; if (time_left !== TW'(GS)) begin errors++; $display("FAIL %s start time_left got %0d want %0d", name, time_left, GS); end
    checks++; if (score !== '0) begin errors++; $display("FAIL %s start score got %0d want 0", name, score); end
    playing = 1'b1; post = 0; exp_score = 0; exp_time = GS;
    for (int n = 1; n <= 400 && post < 3; n++) begin
      nv = stim(mode, arg, n);
      start = (mode == 2 && n < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      score_in = nv;
      @(posedge clock); #1;
      if (playing) begin
        k = $countones(nv & ~prev);
        exp_score = (exp_score + k > SMAX) ? SMAX : exp_score + k;
        exp_tick = (n % HZ == 0);
        t = int'(exp_time) - (exp_tick ? 1 : 0) + (BONUS_ON ? int'(k * BS) : 0);
        if (t > 65535) t = 65535;
        exp_time = t;
        if (exp_tick && t == 0) begin
          playing = 1'b0;
          over_n = n;
          if (exp_score > exp_high) exp_high = exp_score;
        end
      end else begin
        exp_tick = 1'b0;
        post++;
      end
      prev = nv;
      checks++; if (time_left !== exp_time[TW-1:0]) begin errors++; $display("FAIL %s n=%0d time_left got %0d want %0d", name, n, time_left, exp_time); end
      checks++; if (score !== exp_score[SW-1:0]) begin errors++; $display("FAIL %s n=%0d score got %0d want %0d", name, n, score, exp_score); end
      checks++; if (game_active !== playing) begin errors++; $display("FAIL %s n=%0d game_active got %b want %b", name, n, game_active, playing); end
      checks++; if (game_over !== !playing) begin errors++; $display("FAIL %s n=%0d game_over got %b want %b", name, n, game_over, !playing); end
      checks++; if (sec_tick !== exp_tick) begin errors++; $display("FAIL %s n=%0d sec_tick got %b want %b", name, n, sec_tick, exp_tick); end
      checks++; if (high_score !== exp_high[SW-1:0]) begin errors++; $display("FAIL %s n=%0d high_score got %0d want %0d", name, n, high_score, exp_high); end
    end
    checks++; if (playing) begin errors++; $display("FAIL %s timeout game still active got 1 want 0", name); end
    start = 1'b0;
    final_score = exp_score;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (time_left !== TW'(GS)) begin errors++; $display("FAIL reset time_left got %0d want %0d", time_left, GS); end
    checks++; if (score !== '0 || high_score !== '0) begin errors++; $display("FAIL reset scores got %0d/%0d want 0/0", score, high_score); end
    checks++; if ({game_active, game_over, sec_tick} !== 3'b000) begin errors++; $display("FAIL reset flags got %b want 000", {game_active, game_over, sec_tick}); end
    checks++; if (time_left_s !== TW'(GS_SAT)) begin errors++; $display("FAIL reset sat time_left got %0d want %0d", time_left_s, GS_SAT); end
    @(posedge clock); #1;
    reset = 1'b0;
    // Sensor edges in IDLE must be discarded
    for (int n = 0; n < 6; n++) begin
      score_in = (n % 2 == 0) ? 2'b11 : 2'b00;
      @(posedge clock); #1;
      checks++; if (score !== '0 || game_active !== 1'b0) begin errors++; $display("FAIL idle_discard score got %0d active %b want 0 0", score, game_active); end
    end
    score_in = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_timing();
    int on; int unsigned fs;
    run_game(0, 0, "timing", on, fs);
    checks++; if (on !== 12) begin errors++; $display("FAIL timing game length got %0d want 12", on); end
  endtask

  task automatic test_scoring();
    int on; int unsigned fs;
    run_game(1, 0, "scoring", on, fs);
    checks++; if (score !== 4'd3) begin errors++; $display("FAIL scoring final score got %0d want 3", score); end
  endtask

  task automatic test_high_score();
    int on; int unsigned fs;
    run_game(3, 1, "high_1", on, fs);
    checks++; if (high_score !== 4'd3) begin errors++; $display("FAIL high_after_1 got %0d want 3", high_score); end
    run_game(3, 5, "high_5", on, fs);
    checks++; if (high_score !== 4'd5) begin errors++; $display("FAIL high_after_5 got %0d want 5", high_score); end
  endtask

  task automatic test_final_tick();
    int on; int unsigned fs;
    run_game(4, 12, "final_tick", on, fs);
    checks++; if (score !== 4'd1) begin errors++; $display("FAIL final_tick score got %0d want 1", score); end
  endtask

  task automatic test_random();
    int on; int unsigned fs;
    for (int g = 0; g < 3; g++) run_game(2, 0, "random", on, fs);
  endtask

`ifdef CLAWGAME_BONUS_TIME_EN
  task automatic test_bonus();
    int on; int unsigned fs;
    run_game(4, 9, "bonus", on, fs);
    checks++; if (on !== 20) begin errors++; $display("FAIL bonus game length got %0d want 20", on); end
  endtask
`endif

  task automatic test_reset_midgame();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      score_in = (n % 2 == 0) ? 2'b01 : 2'b00;
      @(posedge clock); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (time_left !== TW'(GS)) begin errors++; $display("FAIL midreset time_left got %0d want %0d", time_left, GS); end
    checks++; if (score !== '0 || high_score !== '0) begin errors++; $display("FAIL midreset scores got %0d/%0d want 0/0", score, high_score); end
    checks++; if ({game_active, game_over, sec_tick} !== 3'b000) begin errors++; $display("FAIL midreset flags got %b want 000", {game_active, game_over, sec_tick}); end
    exp_high = 0;
    score_in = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_saturation();
    logic [NC-1:0] prev, v;
    int unsigned cnt, ex;
    prev = score_in_s; cnt = 0;
    start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0;
    checks++; if (game_active_s !== 1'b1) begin errors++; $display("FAIL sat start game_active got %b want 1", game_active_s); end
    for (int n = 1; n <= 28; n++) begin
      v = ((n <= 20 || n > 24) && (n % 2 == 1)) ? 2'b11 : 2'b00;
      score_in_s = v;
      @(posedge clock); #1;
      if (n <= 24) cnt += $countones(v & ~prev);
      prev = v;
      ex = (cnt > SMAX) ? SMAX : cnt;
      checks++; if (score_s !== ex[SW-1:0]) begin errors++; $display("FAIL sat n=%0d score got %0d want %0d", n, score_s, ex); end
`ifndef CLAWGAME_BONUS_TIME_EN
      if (n == 24) begin
        checks++; if (game_over_s !== 1'b1) begin errors++; $display("FAIL sat over at 24 got %b want 1", game_over_s); end
        checks++; if (high_score_s !== 4'd15) begin errors++; $display("FAIL sat high_score got %0d want 15", high_score_s); end
      end
`endif
    end
    score_in_s = '0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_scoring();
    test_high_score();
    test_final_tick();
    test_random();
`ifdef CLAWGAME_BONUS_TIME_EN
    test_bonus();
`endif
    test_reset_midgame();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit got expired want finished");
    $fatal(1);
  end

endmodule
